tlul_host_arb: RTL and testbench

N-to-1 TL-UL arbiter that shares a single register-target device port (a `tlul_adapter_reg`-fronted register block) between several TL-UL hosts. It keeps at most one transaction in flight and selects hosts fairly with round-robin. It routes each response back to the host that issued the request. Integrity and user fields pass through untouched, so downstream command-integrity checking still sees the original host bits.

---
 rtl/tlul_pkg.sv | 39 +++
 rtl/tlul_rr_arb.sv | 41 ++++
 rtl/tlul_host_arb.sv | 123 ++++++++++++
 tb/tb_tlul_host_arb.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlul_pkg.sv
// rtl/tlul_pkg.sv - TL-UL channel types shared by hosts, devices and the arbiter
package tlul_pkg;

    localparam logic [2:0] OP_PUT_FULL    = 3'd0;
    localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] OP_GET         = 3'd4;
    localparam logic [2:0] OP_ACK         = 3'd0;
    localparam logic [2:0] OP_ACK_DATA    = 3'd1;

    // Host-to-device: A-channel request plus the D-channel ready.
    // a_user carries the command/data integrity bits.
    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic [15:0] a_user;
        logic        d_ready;
    } tl_h2d_t;

    // Device-to-host: D-channel response plus the A-channel ready.
    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic [13:0] d_user;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/tlul_rr_arb.sv
// rtl/tlul_rr_arb.sv - combinational round-robin picker
// Ports:
//   req_i   - one request bit per requester
//   ptr_i   - index with highest priority this cycle
//   gnt_o   - first requester found searching upward from ptr_i (wrapping)
//   valid_o - at least one requester is active
module tlul_rr_arb #(
    parameter int N = 2,
    localparam int HW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [HW-1:0] ptr_i,
    output logic [HW-1:0] gnt_o,
    output logic          valid_o
);

    logic [HW:0] w_dist;
    logic [HW:0] w_best;

    // Each requester's priority is its wrapped distance from ptr_i;
    // the smallest distance wins.
    always_comb begin
        gnt_o   = '0;
        valid_o = 1'b0;
        w_best  = (HW+1)'(N);
        w_dist  = '0;
        for (int i = 0; i < N; i++) begin
            if (HW'(i) >= ptr_i) begin
                w_dist = {1'b0, HW'(i) - ptr_i};
            end else begin
                w_dist = (HW+1)'(i + N) - {1'b0, ptr_i};
            end
            if (req_i[HW'(i)] && (w_dist < w_best)) begin
                w_best  = w_dist;
                gnt_o   = HW'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tlul_host_arb.sv
// rtl/tlul_host_arb.sv - N-to-1 TL-UL arbiter, one transaction in flight
// Ports:
//   clk_i, rst_ni - clock, asynchronous active-low reset
//   tl_h_i/tl_h_o - per-host request / response channels
//   tl_d_o/tl_d_i - shared device request / response channel
module tlul_host_arb
    import tlul_pkg::*;
#(
    parameter int NumHosts = 2
) (
    input  logic    clk_i,
    input  logic    rst_ni,
    input  tl_h2d_t tl_h_i [NumHosts],
    output tl_d2h_t tl_h_o [NumHosts],
    output tl_h2d_t tl_d_o,
    input  tl_d2h_t tl_d_i
);

    localparam int HW = $clog2(NumHosts);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RSP
    } state_e;

    state_e              r_state_q;
    state_e              w_state_d;
    logic [HW-1:0]       r_ptr_q;
    logic [HW-1:0]       r_gnt_q;
    logic [NumHosts-1:0] w_req;
    logic [HW-1:0]       w_arb_gnt;
    logic                w_arb_valid;
    logic [HW-1:0]       w_sel;
    logic                w_a_req;
    logic                w_a_ack;
    logic                w_d_ack;

    if (NumHosts < 2 || NumHosts > 8) begin : g_bad_num_hosts
        $error("tlul_host_arb: NumHosts must be within 2..8");
    end

    for (genvar i = 0; i < NumHosts; i++) begin : g_req
        assign w_req[i] = tl_h_i[i].a_valid;
    end

    tlul_rr_arb #(
        .N (NumHosts)
    ) u_rr_arb (
        .req_i   (w_req),
        .ptr_i   (r_ptr_q),
        .gnt_o   (w_arb_gnt),
        .valid_o (w_arb_valid)
    );

    always_comb begin
        w_state_d = r_state_q;
        w_sel     = r_gnt_q;
        w_a_req   = 1'b0;
        w_a_ack   = 1'b0;
        w_d_ack   = 1'b0;
        tl_d_o    = '0;
        tl_h_o    = '{default: '0};
        unique case (r_state_q)
            ST_IDLE, ST_REQ: begin
                // In REQ the grant is frozen so the presented A-phase cannot
                // switch hosts while a_valid is held.
                w_sel = (r_state_q == ST_IDLE) ? w_arb_gnt : r_gnt_q;
                if (tl_h_i[w_sel].a_valid) begin
                    w_a_req               = 1'b1;
                    tl_d_o                = tl_h_i[w_sel];
                    tl_d_o.d_ready        = 1'b0;
                    tl_h_o[w_sel].a_ready = tl_d_i.a_ready;
                    w_a_ack               = tl_d_i.a_ready;
                    w_state_d             = tl_d_i.a_ready ? ST_RSP : ST_REQ;
                end
            end
            ST_RSP: begin
                // Only one transaction is outstanding, so routing comes from
                // the latched grant rather than d_source.
                tl_h_o[r_gnt_q]         = tl_d_i;
                tl_h_o[r_gnt_q].a_ready = 1'b0;
                tl_d_o.d_ready          = tl_h_i[r_gnt_q].d_ready;
                w_d_ack                 = tl_d_i.d_valid & tl_h_i[r_gnt_q].d_ready;
                if (w_d_ack) begin
                    w_state_d = ST_IDLE;
                end
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state_q <= ST_IDLE;
            r_ptr_q   <= '0;
            r_gnt_q   <= '0;
        end else begin
            r_state_q <= w_state_d;
            if (w_a_req) begin
                r_gnt_q <= w_sel;
            end
            if (w_a_ack) begin
                r_ptr_q <= (w_sel == HW'(NumHosts - 1)) ? '0 : w_sel + 1'b1;
            end
        end
    end

    property p_gnt_stable_in_req;
        @(posedge clk_i) disable iff (!rst_ni)
            (r_state_q == ST_REQ) |=> $stable(r_gnt_q);
    endproperty
    a_gnt_stable_in_req: assert property (p_gnt_stable_in_req)
        else $error("tlul_host_arb: grant moved while a request was pending");

    property p_no_dvalid_outside_rsp;
        @(posedge clk_i) disable iff (!rst_ni)
            tl_d_i.d_valid |-> (r_state_q == ST_RSP);
    endproperty
    a_no_dvalid_outside_rsp: assert property (p_no_dvalid_outside_rsp)
        else $error("tlul_host_arb: device d_valid with no transaction outstanding");

endmodule

// File: tb/tb_tlul_host_arb.sv
// tb/tb_tlul_host_arb.sv - self-checking bench for tlul_host_arb
module tb_tlul_host_arb;
    import tlul_pkg::*;

    localparam int N = 3;

    logic    clk_i = 1'b0;
    logic    rst_ni = 1'b0;
    tl_h2d_t tl_h_i [N];
    tl_d2h_t tl_h_o [N];
    tl_h2d_t tl_d_o;
    tl_d2h_t tl_d_i;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_i = ~clk_i;

    tlul_host_arb #(.NumHosts(N)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .tl_h_i (tl_h_i),
        .tl_h_o (tl_h_o),
        .tl_d_o (tl_d_o),
        .tl_d_i (tl_d_i)
    );

    // Reference model: phase 0 = nothing outstanding, 1 = request waiting
    // for acceptance (owner fixed), 2 = waiting for the response.
    int m_phase, m_ptr, m_owner;
    int nx_phase, nx_ptr, nx_owner;

    bit obs_hfire [N];
    bit obs_a_ack, obs_d_ack;
    int grant_log [$];
    int wait_cnt [N];

    bit rand_en = 0;
    int p_req = 0, p_aready = 0, p_dready = 0, lat_max = 0;
    bit dev_pend = 0;
    int dev_lat = 0;

    function automatic void chk_val(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endfunction

    function automatic void chk_h2d(string name, tl_h2d_t act, tl_h2d_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endfunction

    function automatic void chk_d2h(string name, tl_d2h_t act, tl_d2h_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endfunction

    // First requesting host found by searching upward from ptr, wrapping.
    function automatic int rr_pick(int ptr);
        for (int k = 0; k < N; k++) begin
            if (tl_h_i[(ptr + k) % N].a_valid) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic model_check();
        tl_h2d_t ed;
        tl_d2h_t eh [N];
        int g;
        if (!rst_ni) begin
            m_phase = 0; m_ptr = 0; m_owner = 0;
        end
        ed = '0;
        for (int i = 0; i < N; i++) eh[i] = '0;
        nx_phase = m_phase; nx_ptr = m_ptr; nx_owner = m_owner;
        if (m_phase != 2) begin
            g = (m_phase == 0) ? rr_pick(m_ptr) : m_owner;
            if (g >= 0 && tl_h_i[g].a_valid) begin
                ed = tl_h_i[g];
                ed.d_ready = 1'b0;
                eh[g].a_ready = tl_d_i.a_ready;
                nx_owner = g;
                if (tl_d_i.a_ready) begin
                    nx_phase = 2;
                    nx_ptr = (g + 1) % N;
                end else begin
                    nx_phase = 1;
                end
            end
        end else begin
            eh[m_owner] = tl_d_i;
            eh[m_owner].a_ready = 1'b0;
            ed.d_ready = tl_h_i[m_owner].d_ready;
            if (tl_d_i.d_valid && tl_h_i[m_owner].d_ready) nx_phase = 0;
        end
        if (!rst_ni) begin
            nx_phase = 0; nx_ptr = 0; nx_owner = 0;
        end
        chk_h2d("model tl_d_o", tl_d_o, ed);
        for (int i = 0; i < N; i++) chk_d2h($sformatf("model tl_h_o[%0d]", i), tl_h_o[i], eh[i]);
    endtask

    // Records handshakes the DUT performed; checks the fairness bound.
    task automatic observe();
        obs_a_ack = tl_d_o.a_valid && tl_d_i.a_ready;
        obs_d_ack = tl_d_i.d_valid && tl_d_o.d_ready;
        for (int i = 0; i < N; i++) obs_hfire[i] = tl_h_i[i].a_valid && tl_h_o[i].a_ready;
        if (!rst_ni) return;
        for (int j = 0; j < N; j++) begin
            if (obs_hfire[j]) begin
                grant_log.push_back(j);
                for (int i = 0; i < N; i++)
                    if (i != j && tl_h_i[i].a_valid) wait_cnt[i]++;
                chk_val($sformatf("fairness wait host%0d", j), 32'(wait_cnt[j] <= N - 1), 32'd1);
                wait_cnt[j] = 0;
            end
        end
        for (int i = 0; i < N; i++) if (!tl_h_i[i].a_valid) wait_cnt[i] = 0;
    endtask

    task automatic new_req(int i);
        logic keep_dr;
        keep_dr = tl_h_i[i].d_ready;
        tl_h_i[i].a_valid   = 1'b1;
        tl_h_i[i].a_opcode  = ($urandom_range(1) == 1) ? OP_GET : OP_PUT_FULL;
        tl_h_i[i].a_param   = 3'($urandom);
        tl_h_i[i].a_size    = 2'd2;
        tl_h_i[i].a_source  = 8'($urandom);
        tl_h_i[i].a_address = $urandom;
        tl_h_i[i].a_mask    = 4'($urandom);
        tl_h_i[i].a_data    = $urandom;
        tl_h_i[i].a_user    = 16'($urandom);
        tl_h_i[i].d_ready   = keep_dr;
    endtask

    task automatic drive_random();
        for (int i = 0; i < N; i++) begin
            if (tl_h_i[i].a_valid && obs_hfire[i]) tl_h_i[i].a_valid = 1'b0;
            if (!tl_h_i[i].a_valid && int'($urandom_range(99)) < p_req) new_req(i);
            tl_h_i[i].d_ready = int'($urandom_range(99)) < p_dready;
        end
        if (obs_d_ack) begin
            tl_d_i.d_valid = 1'b0;
            dev_pend = 0;
        end
        if (obs_a_ack) begin
            dev_pend = 1;
            dev_lat = int'($urandom_range(lat_max));
        end
        if (!tl_d_i.d_valid) begin
            tl_d_i.d_opcode = 3'($urandom);
            tl_d_i.d_param  = 3'($urandom);
            tl_d_i.d_size   = 2'($urandom);
            tl_d_i.d_source = 8'($urandom);
            tl_d_i.d_sink   = 1'($urandom);
            tl_d_i.d_data   = $urandom;
            tl_d_i.d_user   = 14'($urandom);
            tl_d_i.d_error  = 1'($urandom);
            if (dev_pend) begin
                if (dev_lat == 0) tl_d_i.d_valid = 1'b1;
                else dev_lat--;
            end
        end
        tl_d_i.a_ready = int'($urandom_range(99)) < p_aready;
    endtask

    task automatic step();
        @(negedge clk_i);
        model_check();
        observe();
        @(posedge clk_i);
        m_phase = nx_phase; m_ptr = nx_ptr; m_owner = nx_owner;
        #1;
        if (rand_en) drive_random();
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < N; i++) begin
            tl_h_i[i] = '0;
            obs_hfire[i] = 0;
            wait_cnt[i] = 0;
        end
        tl_d_i = '0;
        obs_a_ack = 0; obs_d_ack = 0;
        dev_pend = 0; dev_lat = 0;
        rand_en = 0;
    endtask

    task automatic chk_all_zero(string tag);
        chk_h2d({tag, " tl_d_o zero"}, tl_d_o, '0);
        for (int i = 0; i < N; i++) chk_d2h($sformatf("%s tl_h_o[%0d] zero", tag, i), tl_h_o[i], '0);
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        clear_inputs();
        grant_log.delete();
        step();
        step();
        rst_ni = 1'b1;
    endtask

    int exp_ord [6] = '{0, 1, 2, 0, 1, 2};
    int hits [N];

    initial begin
        clear_inputs();
        do_reset();
        #1 chk_all_zero("reset");

        // Single Get from host 0, response one cycle later.
        do_reset();
        tl_h_i[0].a_valid = 1'b1; tl_h_i[0].a_opcode = OP_GET; tl_h_i[0].a_address = 32'h10;
        tl_h_i[0].a_size = 2'd2; tl_h_i[0].a_mask = 4'hf; tl_h_i[0].a_source = 8'h01;
        tl_d_i.a_ready = 1'b1;
        #1;
        chk_val("t1 a_ready same cycle", 32'(tl_h_o[0].a_ready), 32'd1);
        chk_val("t1 device address", tl_d_o.a_address, 32'h10);
        step();
        tl_h_i[0].a_valid = 1'b0; tl_h_i[0].d_ready = 1'b1; tl_d_i.a_ready = 1'b0;
        tl_d_i.d_valid = 1'b1; tl_d_i.d_opcode = OP_ACK_DATA; tl_d_i.d_data = 32'hA5A5_0000; tl_d_i.d_source = 8'h01;
        #1;
        chk_val("t1 host0 d_valid", 32'(tl_h_o[0].d_valid), 32'd1);
        chk_val("t1 host0 d_data", tl_h_o[0].d_data, 32'hA5A5_0000);
        chk_val("t1 host1 no d_valid", 32'(tl_h_o[1].d_valid), 32'd0);
        step();
        tl_d_i.d_valid = 1'b0;
        step();

        // All hosts request continuously: strict rotation.
        do_reset();
        p_req = 100; p_aready = 100; p_dready = 100; lat_max = 0; rand_en = 1;
        drive_random();
        repeat (14) step();
        rand_en = 0;
        chk_val("t2 grant count", 32'(grant_log.size() >= 6), 32'd1);
        for (int k = 0; k < 6; k++)
            if (k < grant_log.size()) chk_val($sformatf("t2 grant order %0d", k), 32'(grant_log[k]), 32'(exp_ord[k]));

        // Device stalls host 1; host 0 arrives meanwhile and must wait.
        do_reset();
        tl_h_i[1].a_valid = 1'b1; tl_h_i[1].a_opcode = OP_PUT_FULL; tl_h_i[1].a_source = 8'h11;
        tl_d_i.a_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) begin
                tl_h_i[0].a_valid = 1'b1; tl_h_i[0].a_source = 8'h22;
            end
            #1;
            chk_val($sformatf("t3 hold source c%0d", c), 32'(tl_d_o.a_source), 32'h11);
            chk_val($sformatf("t3 host0 a_ready c%0d", c), 32'(tl_h_o[0].a_ready), 32'd0);
            step();
        end
        tl_d_i.a_ready = 1'b1;
        #1;
        chk_val("t3 host1 accepted", 32'(tl_h_o[1].a_ready), 32'd1);
        chk_val("t3 host0 not accepted", 32'(tl_h_o[0].a_ready), 32'd0);
        step();
        tl_h_i[1].a_valid = 1'b0; tl_h_i[1].d_ready = 1'b1; tl_d_i.a_ready = 1'b0;
        tl_d_i.d_valid = 1'b1; tl_d_i.d_opcode = OP_ACK;
        #1;
        chk_val("t3 host1 d_valid", 32'(tl_h_o[1].d_valid), 32'd1);
        chk_val("t3 host0 no d_valid", 32'(tl_h_o[0].d_valid), 32'd0);
        step();
        tl_d_i.d_valid = 1'b0;
        #1 chk_val("t3 host0 next", 32'(tl_d_o.a_source), 32'h22);
        step();
        tl_d_i.a_ready = 1'b1;
        step();
        tl_h_i[0].a_valid = 1'b0; tl_h_i[0].d_ready = 1'b1; tl_d_i.a_ready = 1'b0; tl_d_i.d_valid = 1'b1;
        step();
        tl_d_i.d_valid = 1'b0;
        step();

        // Host 1 back-pressures the response for four cycles.
        do_reset();
        tl_h_i[1].a_valid = 1'b1; tl_h_i[1].a_source = 8'h33; tl_d_i.a_ready = 1'b1;
        step();
        tl_h_i[1].a_valid = 1'b0; tl_h_i[1].d_ready = 1'b0;
        tl_h_i[0].a_valid = 1'b1; tl_h_i[0].a_source = 8'h44;
        tl_d_i.d_valid = 1'b1; tl_d_i.d_opcode = OP_ACK_DATA; tl_d_i.d_data = 32'h1234_5678;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk_val($sformatf("t4 device d_ready c%0d", c), 32'(tl_d_o.d_ready), 32'd0);
            chk_val($sformatf("t4 d_data stable c%0d", c), tl_h_o[1].d_data, 32'h1234_5678);
            chk_val($sformatf("t4 no new A c%0d", c), 32'(tl_d_o.a_valid), 32'd0);
            step();
        end
        tl_h_i[1].d_ready = 1'b1;
        #1 chk_val("t4 device d_ready released", 32'(tl_d_o.d_ready), 32'd1);
        step();
        tl_d_i.d_valid = 1'b0;
        #1 chk_val("t4 host0 after d_ack", 32'(tl_d_o.a_source), 32'h44);
        step();
        tl_h_i[0].a_valid = 1'b0; tl_h_i[0].d_ready = 1'b1; tl_d_i.d_valid = 1'b1;
        step();
        tl_d_i.d_valid = 1'b0;
        step();

        // Reset while the response is pending; pointer must return to 0.
        do_reset();
        tl_h_i[0].a_valid = 1'b1; tl_h_i[0].a_source = 8'h01; tl_d_i.a_ready = 1'b1;
        step();
        tl_h_i[0].a_valid = 1'b0; tl_d_i.a_ready = 1'b0;
        step();
        rst_ni = 1'b0;
        clear_inputs();
        #1 chk_all_zero("t5 in reset");
        step();
        step();
        rst_ni = 1'b1;
        tl_h_i[0].a_valid = 1'b1; tl_h_i[0].a_source = 8'h66;
        tl_h_i[1].a_valid = 1'b1; tl_h_i[1].a_source = 8'h77;
        #1 chk_val("t5 host0 wins after reset", 32'(tl_d_o.a_source), 32'h66);
        step();

        // Randomized traffic against the model.
        do_reset();
        p_req = 35; p_aready = 60; p_dready = 70; lat_max = 3; rand_en = 1;
        drive_random();
        repeat (3000) step();
        rand_en = 0;
        for (int i = 0; i < N; i++) hits[i] = 0;
        foreach (grant_log[k]) hits[grant_log[k]]++;
        for (int i = 0; i < N; i++) chk_val($sformatf("random host%0d served", i), 32'(hits[i] > 0), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
